// File: rtl/dpsram_fifo_ctrl_if.sv
// Handshake and SRAM-side bundle for dpsram_fifo_ctrl.
// The slave modport is the controller; the master modport is the producer/consumer/SRAM side.
interface dpsram_fifo_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 4
);
  logic          push;
  logic [DW-1:0] push_data;
  logic          full;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          empty;
  logic [AW:0]   count;
  logic          mem_wr;
  logic [AW-1:0] mem_ad1;
  logic [DW-1:0] mem_da1;
  logic          mem_rd;
  logic [AW-1:0] mem_ad2;
  logic [DW-1:0] mem_do2;

  modport slave (
    input  push, push_data, pop, mem_do2,
    output full, pop_data, pop_valid, empty, count,
           mem_wr, mem_ad1, mem_da1, mem_rd, mem_ad2
  );

  modport master (
    output push, push_data, pop, mem_do2,
    input  full, pop_data, pop_valid, empty, count,
           mem_wr, mem_ad1, mem_da1, mem_rd, mem_ad2
  );
endinterface

// File: rtl/dpsram_fifo_ctrl.sv
// Circular-buffer controller driving a dual-port SRAM (write port 1, read port 2).
// Optional sticky overflow/underflow flags: define DPSRAM_FIFO_ERRFLAG_EN.
module dpsram_fifo_ctrl #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rs,
  dpsram_fifo_ctrl_if.slave bus
`ifdef DPSRAM_FIFO_ERRFLAG_EN
  ,
  output logic              ovf,
  output logic              unf
`endif
);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_pop_valid;
  logic          w_empty;
  logic          w_full;
  logic          w_push_acc;
  logic          w_pop_acc;
  logic [DW-1:0] w_rd_word;

  // Extra wrap bit distinguishes full from empty when the low bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // Strobes are gated by reset so nothing reaches the SRAM while rs is low.
  assign w_push_acc = bus.push & ~w_full & rs;
  assign w_pop_acc  = bus.pop & ~w_empty & rs;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop_acc)  r_rptr <= r_rptr + 1'b1;
      r_pop_valid <= w_pop_acc;
    end
  end

  assign w_rd_word = bus.mem_do2;

  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_wptr - r_rptr;
  assign bus.mem_wr    = w_push_acc;
  assign bus.mem_ad1   = r_wptr[AW-1:0];
  assign bus.mem_da1   = bus.push_data;
  assign bus.mem_rd    = w_pop_acc;
  assign bus.mem_ad2   = r_rptr[AW-1:0];
  assign bus.pop_valid = r_pop_valid;
  assign bus.pop_data  = w_rd_word;

`ifdef DPSRAM_FIFO_ERRFLAG_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (bus.push & w_full)  r_ovf <= 1'b1;
      if (bus.pop & w_empty)  r_unf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
  assign unf = r_unf;
`endif

endmodule

// File: tb/tb_dpsram_fifo_ctrl.sv
// Scoreboard bench for dpsram_fifo_ctrl with a behavioural SRAM and a queue-based FIFO model.
module tb_dpsram_fifo_ctrl;
  localparam int AW = 3;
  localparam int DW = 4;
  localparam int DEPTH = 2 ** AW;

  logic clk;
  logic rs;

  dpsram_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DPSRAM_FIFO_ERRFLAG_EN
  logic ovf;
  logic unf;
  dpsram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rs(rs), .bus(bus), .ovf(ovf), .unf(unf));
`else
  dpsram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rs(rs), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write on port 1, registered read on port 2.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_ad1] <= bus.mem_da1;
    if (bus.mem_rd) bus.mem_do2 <= mem[bus.mem_ad2];
  end

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  int  widx, ridx;
  bit  exp_pv;
  bit  m_ovf, m_unf;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    widx = 0;
    ridx = 0;
    exp_pv = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock cycle of stimulus: check registered outputs, drive, check strobes, advance model.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
    bit acc_p, acc_q;
    @(negedge clk);
    chk("count", int'(bus.count), model_q.size());
    chk("empty", int'(bus.empty), int'(model_q.size() == 0));
    chk("full", int'(bus.full), int'(model_q.size() == DEPTH));
    chk("pop_valid", int'(bus.pop_valid), int'(exp_pv));
`ifdef DPSRAM_FIFO_ERRFLAG_EN
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("unf", int'(unf), int'(m_unf));
`endif
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = q;
    acc_p = p && (model_q.size() < DEPTH);
    acc_q = q && (model_q.size() > 0);
    #1;
    chk("mem_wr", int'(bus.mem_wr), int'(acc_p));
    chk("mem_rd", int'(bus.mem_rd), int'(acc_q));
    chk("mem_ad1", int'(bus.mem_ad1), widx % DEPTH);
    chk("mem_ad2", int'(bus.mem_ad2), ridx % DEPTH);
    if (acc_p) chk("mem_da1", int'(bus.mem_da1), int'(d));
    if (p && !acc_p) m_ovf = 1'b1;
    if (q && model_q.size() == 0) m_unf = 1'b1;
    if (acc_q) begin
      exp_q.push_back(model_q.pop_front());
      ridx++;
    end
    if (acc_p) begin
      model_q.push_back(d);
      widx++;
    end
    exp_pv = acc_q;
  endtask

  // Monitor: every presented word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rs && bus.pop_valid) begin
      if (exp_q.size() == 0) chk("pop_spurious", 1, 0);
      else chk("pop_data", int'(bus.pop_data), int'(exp_q.pop_front()));
    end
  end

  initial begin
    model_reset();
    rs = 1'b0;
    bus.push = 1'b1;
    bus.push_data = 4'h5;
    bus.pop = 1'b0;
    #3;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_mem_wr", int'(bus.mem_wr), 0);
    chk("rst_pop_valid", int'(bus.pop_valid), 0);
    chk("rst_mem_ad1", int'(bus.mem_ad1), 0);
    chk("rst_full", int'(bus.full), 0);
    bus.push = 1'b0;
    @(negedge clk);
    rs = 1'b1;

    // Fill, then one push too many.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'h9, 1'b0);
    // Drain, then one idle cycle so the last word and empty are observed.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    // Simultaneous push/pop at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 2), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'hA, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    // Push/pop pairs crossing the address wrap, then a pop at empty.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      step(1'b0, 4'h0, 1'b1);
    end
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    // Reset in the middle of a pop.
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i + 7), 1'b0);
    step(1'b0, 4'h0, 1'b1);
    @(posedge clk);
    #2;
    chk("mid_pv_before", int'(bus.pop_valid), 1);
    chk("mid_count_before", int'(bus.count), 5);
    bus.push = 1'b1;
    bus.pop = 1'b0;
    rs = 1'b0;
    #1;
    chk("mid_pop_valid", int'(bus.pop_valid), 0);
    chk("mid_count", int'(bus.count), 0);
    chk("mid_empty", int'(bus.empty), 1);
    chk("mid_mem_wr", int'(bus.mem_wr), 0);
    model_reset();
    bus.push = 1'b0;
    @(negedge clk);
    rs = 1'b1;
    step(1'b1, 4'h3, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, 4'($urandom_range(0, 15)), $urandom_range(0, 99) < 50);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
